// File: rtl/win_closest_avg.sv
// ---------------------------------------------------------------------------
// win_closest_avg
//
// Sliding-window "closest-to-mean" filter. The block keeps the last DEPTH
// unsigned samples in a circular buffer together with a running sum. Every
// accepted sample that leaves the window full starts one result computation:
//   1. AVG    : register the window average (floor, or round-half-up when
//               WCA_ROUND_AVG_EN is defined)
//   2. SEARCH : walk the window oldest -> newest, one entry per cycle, with a
//               single comparator, remembering the entry nearest the average
//   3. LOAD   : move the winner into the output registers
//   4. OUT    : present dout/out_idx until the consumer takes them
// No new sample is accepted between the triggering accept and the output
// handshake.
//
// Optional feature macro: WCA_ROUND_AVG_EN
//   defined   -> avg = floor((sum + DEPTH/2) / DEPTH)  (round half up)
//   undefined -> avg = floor(sum / DEPTH)
//
// Parameters:
//   DW     sample width in bits (>= 2)
//   DEPTH  window length in samples (2..64)
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   in_valid   din is valid
//   in_ready   block can accept din this cycle
//   din        unsigned input sample
//   out_valid  dout/out_idx are valid
//   out_ready  consumer accepts the result
//   dout       selected window sample
//   out_idx    position of dout in the window (0 = oldest, DEPTH-1 = newest)
//   win_full   window has held DEPTH samples since reset
// ---------------------------------------------------------------------------
module win_closest_avg #(
    parameter int DW    = 16,
    parameter int DEPTH = 12
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DW-1:0]            din,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DW-1:0]            dout,
    output logic [$clog2(DEPTH)-1:0] out_idx,
    output logic                     win_full
);

    localparam int IW = $clog2(DEPTH);
    localparam int SW = DW + IW;
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [2:0] S_FILL   = 3'd0;
    localparam logic [2:0] S_WAIT   = 3'd1;
    localparam logic [2:0] S_AVG    = 3'd2;
    localparam logic [2:0] S_SEARCH = 3'd3;
    localparam logic [2:0] S_LOAD   = 3'd4;
    localparam logic [2:0] S_OUT    = 3'd5;

    logic [2:0]    state;

    logic [DW-1:0] mem [DEPTH];
    logic [IW-1:0] wr_ptr;
    logic [IW-1:0] wr_ptr_next;
    logic [CW-1:0] count;
    logic [CW-1:0] count_inc;
    logic [SW-1:0] sum;

    logic [DW-1:0] avg;
    logic [DW-1:0] avg_next;

    logic [IW-1:0] scan_k;
    logic [IW:0]   pos_sum;
    logic [IW-1:0] rd_addr;
    logic [DW-1:0] cur;
    logic [DW-1:0] oldest;
    logic [DW-1:0] diff;

    logic [DW-1:0] best_diff;
    logic [DW-1:0] best_val;
    logic [IW-1:0] best_idx;

    logic          accept;
    logic          scan_last;

    // Input is only taken while collecting or idling with a full window.
    assign in_ready = (state == S_FILL) || (state == S_WAIT);
    assign accept   = in_valid && in_ready;

    assign wr_ptr_next = (wr_ptr == IW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
    assign count_inc   = count + 1'b1;

    // Once the window is full the write pointer always sits on the oldest
    // entry, so window position k lives at (wr_ptr + k) mod DEPTH. Both
    // operands are below DEPTH, so one conditional subtract is enough.
    assign pos_sum = {1'b0, wr_ptr} + {1'b0, scan_k};
    assign rd_addr = (pos_sum >= (IW + 1)'(DEPTH))
                   ? IW'(pos_sum - (IW + 1)'(DEPTH))
                   : IW'(pos_sum);

    assign cur       = mem[rd_addr];
    assign oldest    = mem[wr_ptr];
    assign scan_last = (scan_k == IW'(DEPTH - 1));

    // Unsigned distance, always non-negative by ordering the operands.
    assign diff = (cur >= avg) ? (cur - avg) : (avg - cur);

`ifdef WCA_ROUND_AVG_EN
    // Adding DEPTH/2 before the divide rounds half up; the extra bit keeps
    // the biased maximum window sum from wrapping.
    logic [SW:0] biased_sum;
    assign biased_sum = {1'b0, sum} + (SW + 1)'(DEPTH / 2);
    assign avg_next   = DW'(biased_sum / (SW + 1)'(DEPTH));
`else
    assign avg_next = DW'(sum / SW'(DEPTH));
`endif

    // Sample storage carries no reset so it can map onto plain RAM; the
    // count and write pointer decide which entries are meaningful.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr] <= din;
        end
    end

    // Control FSM plus window bookkeeping (pointer, count, running sum).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_FILL;
            wr_ptr   <= '0;
            count    <= '0;
            sum      <= '0;
            win_full <= 1'b0;
        end else begin
            case (state)
                S_FILL: begin
                    if (accept) begin
                        sum    <= sum + SW'(din);
                        count  <= count_inc;
                        wr_ptr <= wr_ptr_next;
                        if (count_inc == CW'(DEPTH)) begin
                            win_full <= 1'b1;
                            state    <= S_AVG;
                        end
                    end
                end
                S_WAIT: begin
                    if (accept) begin
                        sum    <= sum - SW'(oldest) + SW'(din);
                        wr_ptr <= wr_ptr_next;
                        state  <= S_AVG;
                    end
                end
                S_AVG: begin
                    state <= S_SEARCH;
                end
                S_SEARCH: begin
                    if (scan_last) begin
                        state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    state <= S_OUT;
                end
                S_OUT: begin
                    if (out_ready) begin
                        state <= S_WAIT;
                    end
                end
                default: begin
                    state <= S_FILL;
                end
            endcase
        end
    end

    // Average capture and the single-comparator search. Only a strictly
    // smaller distance replaces the current best, so ties keep the oldest.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            avg       <= '0;
            scan_k    <= '0;
            best_diff <= '1;
            best_val  <= '0;
            best_idx  <= '0;
        end else begin
            if (state == S_AVG) begin
                avg       <= avg_next;
                scan_k    <= '0;
                best_diff <= '1;
                best_val  <= '0;
                best_idx  <= '0;
            end else if (state == S_SEARCH) begin
                if (diff < best_diff) begin
                    best_diff <= diff;
                    best_val  <= cur;
                    best_idx  <= scan_k;
                end
                if (!scan_last) begin
                    scan_k <= scan_k + 1'b1;
                end
            end
        end
    end

    // Output registers: loaded once per result, held while the consumer
    // stalls, and dropped on the handshake edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            dout      <= '0;
            out_idx   <= '0;
        end else begin
            if (state == S_LOAD) begin
                out_valid <= 1'b1;
                dout      <= best_val;
                out_idx   <= best_idx;
            end else if ((state == S_OUT) && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_win_closest_avg.sv
// ---------------------------------------------------------------------------
// tb_win_closest_avg
//
// Directed bench for win_closest_avg (DW=16, DEPTH=12). A queue-based model
// of the window computes the expected result for every trigger; a compare
// process checks handshake signals and results on every falling edge, and
// the directed sequence pins the model with hand-computed literals.
// ---------------------------------------------------------------------------
module tb_win_closest_avg;

    localparam int DW    = 16;
    localparam int DEPTH = 12;
    localparam int IW    = $clog2(DEPTH);
    localparam int LAT   = DEPTH + 2;

`ifdef WCA_ROUND_AVG_EN
    localparam int R1D = 7;
    localparam int R1I = 6;
    localparam int R2D = 8;
    localparam int R2I = 6;
    localparam int R3D = 9;
    localparam int R3I = 6;
`else
    localparam int R1D = 6;
    localparam int R1I = 5;
    localparam int R2D = 7;
    localparam int R2I = 5;
    localparam int R3D = 8;
    localparam int R3I = 5;
`endif

    logic          clk       = 1'b0;
    logic          reset     = 1'b1;
    logic          in_valid  = 1'b0;
    logic          out_ready = 1'b1;
    logic [DW-1:0] din       = '0;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] dout;
    logic [IW-1:0] out_idx;
    logic          win_full;

    int vectors     = 0;
    int miscompares = 0;
    bit check_en    = 1'b0;

    win_closest_avg #(.DW(DW), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .din       (din),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dout      (dout),
        .out_idx   (out_idx),
        .win_full  (win_full)
    );

    always #5 clk = ~clk;

    // Model state: window contents oldest-first, busy from trigger until
    // the result handshake, and the cycle of the triggering accept.
    logic [DW-1:0] win_q [$];
    bit            m_busy = 1'b0;
    bit            m_full = 1'b0;
    longint        m_cyc  = 0;
    longint        m_trig = 0;
    logic [DW-1:0] m_dout = '0;
    int            m_idx  = 0;

    function automatic void computeExpected();
        longint s = 0;
        longint a;
        longint bestd = 64'h7fff_ffff_ffff;
        longint d;
        foreach (win_q[i]) s += longint'(win_q[i]);
`ifdef WCA_ROUND_AVG_EN
        a = (s + DEPTH / 2) / DEPTH;
`else
        a = s / DEPTH;
`endif
        foreach (win_q[i]) begin
            d = (longint'(win_q[i]) > a) ? longint'(win_q[i]) - a : a - longint'(win_q[i]);
            if (d < bestd) begin
                bestd  = d;
                m_dout = win_q[i];
                m_idx  = i;
            end
        end
    endfunction

    function automatic bit expValid();
        return m_busy && (m_cyc >= m_trig + LAT);
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            win_q.delete();
            m_busy = 1'b0;
            m_full = 1'b0;
            m_cyc  = 0;
            m_trig = 0;
        end else begin
            m_cyc++;
            if (m_busy) begin
                if ((m_cyc - 1 >= m_trig + LAT) && out_ready) m_busy = 1'b0;
            end else if (in_valid) begin
                win_q.push_back(din);
                if (win_q.size() > DEPTH) void'(win_q.pop_front());
                if (win_q.size() == DEPTH) begin
                    m_full = 1'b1;
                    computeExpected();
                    m_busy = 1'b1;
                    m_trig = m_cyc;
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (check_en && !reset) begin
            checkOutput("in_ready", 32'(in_ready), 32'(!m_busy));
            checkOutput("out_valid", 32'(out_valid), 32'(expValid()));
            checkOutput("win_full", 32'(win_full), 32'(m_full));
            if (expValid()) begin
                checkOutput("dout", 32'(dout), 32'(m_dout));
                checkOutput("out_idx", 32'(out_idx), 32'(m_idx));
            end
        end
    end

    // Offer one sample and hold it until accepted (bounded).
    task automatic applyStimulus(input logic [DW-1:0] v);
        bit got = 1'b0;
        int n   = 0;
        din      = v;
        in_valid = 1'b1;
        while (!got && n < 100) begin
            got = in_ready;
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        in_valid = 1'b0;
        checkOutput("accept", 32'(got), 32'd1);
    endtask

    // Wait for a result after the triggering accept and check it literally.
    task automatic waitResult(input int exp_d, input int exp_i);
        int lat = 0;
        while (!out_valid && lat < 60) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        checkOutput("latency", 32'(lat), 32'(LAT));
        checkOutput("lit_dout", 32'(dout), 32'(exp_d));
        checkOutput("lit_idx", 32'(out_idx), 32'(exp_i));
        if (out_ready) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (2) @(negedge clk);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_dout", 32'(dout), 32'd0);
        checkOutput("rst_out_idx", 32'(out_idx), 32'd0);
        checkOutput("rst_win_full", 32'(win_full), 32'd0);
        reset    = 1'b0;
        check_en = 1'b1;
        @(negedge clk);

        // Ramp 1..12, then slide in 13 and 14.
        for (int v = 1; v <= 12; v++) applyStimulus(DW'(v));
        waitResult(R1D, R1I);
        applyStimulus(16'd13);
        waitResult(R2D, R2I);
        applyStimulus(16'd14);
        waitResult(R3D, R3I);

        // Alternating 0/20: every distance ties, oldest position wins.
        for (int i = 0; i < 12; i++) applyStimulus((i % 2) ? 16'd20 : 16'd0);
        waitResult(0, 0);

        // Backpressure: result held, extra sample refused.
        out_ready = 1'b0;
        applyStimulus(16'd50);
        waitResult(20, 0);
        din      = 16'd99;
        in_valid = 1'b1;
        repeat (5) begin
            @(posedge clk);
            @(negedge clk);
            checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
            checkOutput("bp_dout", 32'(dout), 32'd20);
            checkOutput("bp_idx", 32'(out_idx), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("bp_release_valid", 32'(out_valid), 32'd0);
        checkOutput("bp_release_ready", 32'(in_ready), 32'd1);

        // Full-scale samples: sum must not wrap.
        for (int i = 0; i < 12; i++) applyStimulus(16'hFFFF);
        waitResult(32'hFFFF, 0);

        // Reset while searching, then refill from empty.
        applyStimulus(16'd5);
        repeat (4) begin
            @(posedge clk);
            @(negedge clk);
        end
        #2 reset = 1'b1;
        #1;
        checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("midrst_win_full", 32'(win_full), 32'd0);
        checkOutput("midrst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        for (int v = 1; v <= 12; v++) applyStimulus(DW'(v));
        waitResult(R1D, R1I);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
